mac_dot_product_unit: RTL
=========================

Name: mac_dot_product_unit

Overview:
- Sequential multiply-accumulate stage of the matrix multiplication accelerator.
- Consumes 4-bit element pairs (row of A, column of B) from the 4-bit operand registers, one pair per accepted beat.
- Produces a 10-bit dot product after N_TERMS beats, which the downstream 10-bit result register captures.
- Uses valid/ready handshakes on both sides, a synchronous flush, and a sticky overflow flag.

Parameters:
N_TERMS, 3, number of products summed per dot product (legal range 1..15)
A_W, 4, operand width in bits (a_in and b_in)
ACC_W, 10, accumulator and result width in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
clr  input  1  reset, asynchronous, active-high; forces every register to its reset value
flush  input  1  synchronous abort; discards the partial sum and returns to IDLE
a_in  input  A_W  operand A element, unsigned
b_in  input  A_W  operand B element, unsigned
in_valid  input  1  a_in/b_in hold a valid pair
in_ready  output  1  block accepts a pair this cycle
result  output  ACC_W  completed dot product, modulo 2^ACC_W
ovf  output  1  sum of the current vector exceeded 2^ACC_W-1
out_valid  output  1  result/ovf are valid
out_ready  input  1  downstream has captured result
busy  output  1  a vector is in progress (state ACC or HOLD)

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; acc=0, cnt=0, result=0, ovf=0, out_valid=0. in_ready=1 once clr is deasserted. busy=0.
- A beat is accepted when in_valid && in_ready at a rising edge.
- prod = a_in*b_in, 2*A_W bits, zero-extended to ACC_W+1. The sum is formed at ACC_W+1 bits; bit ACC_W is the carry.
- in_ready = (state != HOLD) && !flush. This is combinational.
- IDLE:
  - On accept: acc <= prod; cnt <= 1; ovf_int <= 0.
  - If N_TERMS==1: go to HOLD with result <= prod and ovf <= 0.
  - Otherwise go to ACC.
- ACC:
  - On accept: sum = acc + prod; ovf_int |= carry.
  - If cnt+1 == N_TERMS: result <= sum[ACC_W-1:0]; ovf <= ovf_int | carry; out_valid <= 1; go to HOLD.
  - Otherwise: acc <= sum[ACC_W-1:0]; cnt <= cnt+1.
  - A cycle without a beat leaves the state unchanged. There are no timeouts.
- HOLD:
  - out_valid=1. result and ovf are stable. in_ready=0.
  - On out_ready=1 at the edge: out_valid <= 0; acc <= 0; cnt <= 0; go to IDLE.
  - result and ovf keep their last value after leaving HOLD until the next completion.
- Latency: out_valid rises on the edge that accepts beat N_TERMS, so result is visible the cycle after the last beat. Minimum vector period is N_TERMS+1 cycles with out_ready held high.
- flush:
  - Any state: next state IDLE; acc=0, cnt=0, out_valid=0.
  - result and ovf are unchanged.
  - flush has priority over a simultaneous beat, which is not accepted because in_ready is low, and over a simultaneous out_ready.
- Reset mid-vector or in HOLD: partial sum lost, all outputs take their reset values immediately. No beat is accepted while clr=1.
- Wrap-around: result is the sum modulo 2^ACC_W. ovf is set if any intermediate carry occurred during the vector.
- With defaults the maximum sum is 3*225 = 675, so ovf never sets.
- busy = (state != IDLE).
- cnt is wide enough to hold N_TERMS (4 bits).

Test Plan:
1. Basic dot product, defaults.
   - Stimulus: clr pulse, then beats (1,4),(2,5),(3,6) on consecutive cycles, out_ready=1.
   - Required: result=32, ovf=0, out_valid high exactly 1 cycle, one cycle after the 3rd beat; in_ready=0 during that cycle.
2. Maximum operands.
   - Stimulus: 3 beats of (15,15).
   - Required: result=675, ovf=0.
   - Stimulus: back-to-back vector (0,7),(7,0),(1,1).
   - Required: result=1. The first vector's residue must not leak into the second.
3. Backpressure and gaps.
   - Stimulus: in_valid toggled with idle gaps; out_ready=0 for 5 cycles after completion.
   - Required: out_valid and result=32 stable for all 5 cycles; in_ready=0 throughout; IDLE entered on the first out_ready=1 edge.
4. Flush mid-vector.
   - Stimulus: accept (9,9),(9,9); on the 3rd beat assert flush with in_valid=1.
   - Required: beat not accepted, out_valid stays 0, busy=0 next cycle.
   - Stimulus: a new vector (1,1),(1,1),(1,1).
   - Required: result=3.
5. Async reset in HOLD.
   - Stimulus: complete a vector with out_ready=0, then assert clr between clock edges.
   - Required: out_valid=0, result=0, ovf=0, busy=0 immediately, without waiting for a clk edge.
6. Overflow, N_TERMS=5.
   - Stimulus: 5 beats of (15,15).
   - Required: result=1125-1024=101, ovf=1.
   - Stimulus: next vector of 5 beats of (1,2).
   - Required: result=10, ovf=0.

Source files
------------

// File: rtl/mac_dot_product_unit.sv
// rtl/mac_dot_product_unit.sv - sequential multiply-accumulate dot product stage
module mac_dot_product_unit #(
   parameter int N_TERMS = 3,
   parameter int A_W     = 4,
   parameter int ACC_W   = 10
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             flush,
   input  logic [A_W-1:0]   a_in,
   input  logic [A_W-1:0]   b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] result,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // Beat counter compares against the vector length truncated to its own width.
   localparam logic [3:0] LAST_CNT = 4'(N_TERMS);

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [3:0]       cnt;
   logic             ovf_int;
   logic [2*A_W-1:0] prod;
   logic [ACC_W:0]   prod_ext;
   logic [ACC_W:0]   sum;
   logic             accept;

   // Operands are zero-extended so the product never truncates; sum carries in bit ACC_W.
   always_comb begin
      prod     = {{A_W{1'b0}}, a_in} * {{A_W{1'b0}}, b_in};
      prod_ext = {{(ACC_W + 1 - 2*A_W){1'b0}}, prod};
      sum      = {1'b0, acc} + prod_ext;
   end

   // No beat is taken while holding a result, during a flush, or while reset is held.
   assign in_ready = (state != S_HOLD) && !flush && !clr;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != S_IDLE);

   // Vector sequencing: accumulate N_TERMS accepted products, then hold the result.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf_int   <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  acc     <= prod_ext[ACC_W-1:0];
                  cnt     <= 4'd1;
                  ovf_int <= 1'b0;
                  if (N_TERMS == 1) begin
                     result    <= prod_ext[ACC_W-1:0];
                     ovf       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= S_HOLD;
                  end else begin
                     state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (accept) begin
                  ovf_int <= ovf_int | sum[ACC_W];
                  if (cnt + 4'd1 == LAST_CNT) begin
                     result    <= sum[ACC_W-1:0];
                     ovf       <= ovf_int | sum[ACC_W];
                     out_valid <= 1'b1;
                     state     <= S_HOLD;
                  end else begin
                     acc <= sum[ACC_W-1:0];
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               acc       <= '0;
               cnt       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
